// File: rtl/rand_walk_unit.sv
// rand_walk_unit: bounded random walk driven by a signed random delta stream.
// Holds a saturating position, applies one scaled delta per RUN cycle for a
// programmed number of steps, then pulses done and counts clamped steps.
module rand_walk_unit #(
    parameter logic signed [31:0] POS_MIN    = -32'sd1024,
    parameter logic signed [31:0] POS_MAX    = 32'sd1023,
    parameter int                 STEP_SHIFT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] randNum,
    input  logic               load,
    input  logic signed [31:0] seed_pos,
    input  logic               start,
    input  logic        [7:0]  steps,
    output logic               busy,
    output logic               done,
    output logic signed [31:0] position,
    output logic signed [31:0] last_delta,
    output logic        [7:0]  sat_hits
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bounds widened to the 34-bit arithmetic domain so comparisons never wrap.
    localparam logic signed [33:0] MIN34 = {{2{POS_MIN[31]}}, POS_MIN};
    localparam logic signed [33:0] MAX34 = {{2{POS_MAX[31]}}, POS_MAX};

    logic        [1:0]  state_q, state_d;
    logic        [7:0]  count_q, count_d;
    logic signed [31:0] position_q, position_d;
    logic signed [31:0] last_delta_q, last_delta_d;
    logic        [7:0]  sat_hits_q, sat_hits_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic signed [31:0] delta;
    logic signed [33:0] sum;
    logic               out_of_range;

    // Saturate a widened value into the legal position range.
    function automatic logic signed [31:0] clamp34(input logic signed [33:0] v);
        if (v > MAX34) begin
            return POS_MAX;
        end else if (v < MIN34) begin
            return POS_MIN;
        end else begin
            return v[31:0];
        end
    endfunction

    // Datapath: scaled delta, widened sum and out-of-range flag for this step.
    always_comb begin
        delta        = randNum <<< STEP_SHIFT;
        sum          = $signed({{2{position_q[31]}}, position_q}) + $signed({{2{delta[31]}}, delta});
        out_of_range = (sum > MAX34) || (sum < MIN34);
    end

    // Next-state logic for the IDLE/RUN/DONE controller and the walk registers.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        position_d   = position_q;
        last_delta_d = last_delta_q;
        sat_hits_d   = sat_hits_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // Load wins over a simultaneous start.
                    position_d = clamp34($signed({{2{seed_pos[31]}}, seed_pos}));
                end else if (start) begin
                    count_d    = steps;
                    sat_hits_d = 8'd0;
                    state_d    = (steps != 8'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                position_d   = clamp34(sum);
                last_delta_d = delta;
                if (out_of_range && (sat_hits_q != 8'd255)) begin
                    sat_hits_d = sat_hits_q + 8'd1;
                end
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered copies of the next state decode.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous reset; reset aborts any walk silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 8'd0;
            position_q   <= clamp34(34'sd0);
            last_delta_q <= 32'sd0;
            sat_hits_q   <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            position_q   <= position_d;
            last_delta_q <= last_delta_d;
            sat_hits_q   <= sat_hits_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign position   = position_q;
    assign last_delta = last_delta_q;
    assign sat_hits   = sat_hits_q;

endmodule

// File: tb/tb_rand_walk_unit.sv
// tb_rand_walk_unit: directed tests for rand_walk_unit with hand-computed
// expectations. A second instance with STEP_SHIFT=2 checks delta scaling.
module tb_rand_walk_unit;

    logic               clk;
    logic               reset;
    logic signed [31:0] rand_num;
    logic               load;
    logic signed [31:0] seed_pos;
    logic               start;
    logic        [7:0]  steps;

    logic               busy, done;
    logic signed [31:0] position, last_delta;
    logic        [7:0]  sat_hits;

    logic               busy_s2, done_s2;
    logic signed [31:0] position_s2, last_delta_s2;
    logic        [7:0]  sat_hits_s2;

    int checks = 0;
    int errors = 0;

    rand_walk_unit dut (
        .clock(clk), .reset(reset), .randNum(rand_num), .load(load), .seed_pos(seed_pos),
        .start(start), .steps(steps), .busy(busy), .done(done), .position(position),
        .last_delta(last_delta), .sat_hits(sat_hits)
    );

    rand_walk_unit #(.STEP_SHIFT(2)) dut_s2 (
        .clock(clk), .reset(reset), .randNum(rand_num), .load(load), .seed_pos(seed_pos),
        .start(start), .steps(steps), .busy(busy_s2), .done(done_s2), .position(position_s2),
        .last_delta(last_delta_s2), .sat_hits(sat_hits_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic signed [31:0] seed);
        load = 1'b1; seed_pos = seed;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1; steps = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++; if (position !== 32'sd0) begin errors++; $display("FAIL reset_position: got %0d expected 0", position); end
        checks++; if (last_delta !== 32'sd0) begin errors++; $display("FAIL reset_last_delta: got %0d expected 0", last_delta); end
        checks++; if (sat_hits !== 8'd0) begin errors++; $display("FAIL reset_sat_hits: got %0d expected 0", sat_hits); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        $display("reset: position=%0d busy=%b done=%b", position, busy, done);
    endtask

    task automatic test_walk();
        do_load(32'sd100);
        checks++; if (position !== 32'sd100) begin errors++; $display("FAIL walk_load: got %0d expected 100", position); end
        rand_num = 32'sd7;
        do_start(8'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL walk_busy_start: got %b expected 1", busy); end
        tick();
        checks++; if (position !== 32'sd107) begin errors++; $display("FAIL walk_step1: got %0d expected 107", position); end
        rand_num = -32'sd3;
        tick();
        checks++; if (position !== 32'sd104) begin errors++; $display("FAIL walk_step2: got %0d expected 104", position); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL walk_mid_flags: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        rand_num = 32'sd7;
        tick();
        checks++; if (position !== 32'sd111) begin errors++; $display("FAIL walk_step3: got %0d expected 111", position); end
        checks++; if (last_delta !== 32'sd7) begin errors++; $display("FAIL walk_last_delta: got %0d expected 7", last_delta); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL walk_done: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        checks++; if (sat_hits !== 8'd0) begin errors++; $display("FAIL walk_sat_hits: got %0d expected 0", sat_hits); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL walk_done_width: got %b expected 0", done); end
        $display("walk: final position=%0d last_delta=%0d", position, last_delta);
    endtask

    task automatic test_saturation();
        do_load(32'sd1020);
        rand_num = 32'sd7;
        do_start(8'd2);
        tick();
        checks++; if (position !== 32'sd1023) begin errors++; $display("FAIL sat_hi_step1: got %0d expected 1023", position); end
        tick();
        checks++; if (position !== 32'sd1023) begin errors++; $display("FAIL sat_hi_step2: got %0d expected 1023", position); end
        checks++; if (sat_hits !== 8'd2) begin errors++; $display("FAIL sat_hi_hits: got %0d expected 2", sat_hits); end
        tick();
        do_load(-32'sd1020);
        rand_num = -32'sd7;
        do_start(8'd1);
        tick();
        checks++; if (position !== -32'sd1024) begin errors++; $display("FAIL sat_lo_pos: got %0d expected -1024", position); end
        checks++; if (sat_hits !== 8'd1) begin errors++; $display("FAIL sat_lo_hits: got %0d expected 1", sat_hits); end
        tick();
        // Landing exactly on the bound is not a clamp.
        do_load(32'sd1016);
        rand_num = 32'sd7;
        do_start(8'd1);
        tick();
        checks++; if (position !== 32'sd1023 || sat_hits !== 8'd0) begin errors++; $display("FAIL sat_exact_bound: got pos=%0d hits=%0d expected pos=1023 hits=0", position, sat_hits); end
        tick();
        do_load(32'sd5000);
        checks++; if (position !== 32'sd1023) begin errors++; $display("FAIL sat_load_hi: got %0d expected 1023", position); end
        do_load(-32'sd5000);
        checks++; if (position !== -32'sd1024) begin errors++; $display("FAIL sat_load_lo: got %0d expected -1024", position); end
        $display("saturation: final position=%0d sat_hits=%0d", position, sat_hits);
    endtask

    task automatic test_zero_steps();
        do_load(32'sd50);
        do_start(8'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got busy=%b done=%b expected busy=0 done=1", busy, done); end
        checks++; if (position !== 32'sd50) begin errors++; $display("FAIL zero_position: got %0d expected 50", position); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got busy=%b done=%b expected 0 0", busy, done); end
        load = 1'b1; seed_pos = 32'sd77; start = 1'b1; steps = 8'd3;
        tick();
        load = 1'b0; start = 1'b0;
        checks++; if (position !== 32'sd77 || busy !== 1'b0) begin errors++; $display("FAIL load_priority: got pos=%0d busy=%b expected pos=77 busy=0", position, busy); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL load_priority_idle: got busy=%b done=%b expected 0 0", busy, done); end
        $display("zero_steps: position=%0d", position);
    endtask

    task automatic test_start_during_run();
        do_load(32'sd0);
        rand_num = 32'sd1;
        do_start(8'd3);
        start = 1'b1; steps = 8'd10;
        tick();
        start = 1'b0;
        checks++; if (position !== 32'sd1) begin errors++; $display("FAIL run_ignore_step1: got %0d expected 1", position); end
        tick(); tick();
        checks++; if (position !== 32'sd3 || done !== 1'b1) begin errors++; $display("FAIL run_ignore_len: got pos=%0d done=%b expected pos=3 done=1", position, done); end
        tick();
        do_load(32'sd10);
        rand_num = 32'sd2;
        do_start(8'd5);
        tick();
        checks++; if (position !== 32'sd12) begin errors++; $display("FAIL abort_step1: got %0d expected 12", position); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (position !== 32'sd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_reset: got pos=%0d busy=%b done=%b expected 0 0 0", position, busy, done); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: cycle %0d got busy=%b done=%b expected 0 0", i, busy, done); end
        end
        $display("start_during_run: position=%0d after abort", position);
    endtask

    task automatic test_shift();
        do_load(32'sd0);
        rand_num = 32'hFFFF_FFF9;
        do_start(8'd1);
        tick();
        checks++; if (last_delta_s2 !== -32'sd28) begin errors++; $display("FAIL shift_last_delta: got %0d expected -28", last_delta_s2); end
        checks++; if (position_s2 !== -32'sd28) begin errors++; $display("FAIL shift_position: got %0d expected -28", position_s2); end
        checks++; if (done_s2 !== 1'b1) begin errors++; $display("FAIL shift_done: got %b expected 1", done_s2); end
        checks++; if (position !== -32'sd7) begin errors++; $display("FAIL shift_unscaled: got %0d expected -7", position); end
        tick();
        $display("shift: scaled position=%0d last_delta=%0d", position_s2, last_delta_s2);
    endtask

    initial begin
        reset = 1'b0; rand_num = 32'sd0; load = 1'b0; seed_pos = 32'sd0; start = 1'b0; steps = 8'd0;
        #2;
        test_reset();
        test_walk();
        test_saturation();
        test_zero_steps();
        test_start_during_run();
        test_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
